// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard unit for a 5-stage pipeline: operand forwarding, load-use
//            stall, branch flush, and a RUN/MEM_WAIT FSM that freezes the
//            pipeline while data memory is busy, with a timeout that abandons
//            the access and raises a sticky MemErr.
// Options  : define PIPE_CTRL_PERF_EN to add saturating StallCycles and
//            FlushCount performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemAckM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemBusy,
  output logic       MemErr
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [0:0] c_RUN      = 1'b0;
  localparam logic [0:0] c_MEM_WAIT = 1'b1;
  // Counter value seen in the last permitted wait cycle.
  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] c_RES_LOAD = 2'b01;

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;
  logic       w_lw_stall;
  logic       w_timeout;
  logic       w_mem_stall;

  // Operand forwarding: the younger producer in Memory wins over Writeback; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign w_lw_stall = (ResultSrcE == c_RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // An ack arriving in the final wait cycle wins, so timeout requires !MemAckM.
  assign w_timeout   = (r_state == c_MEM_WAIT) && (r_wait_cnt == c_WAIT_LAST) && !MemAckM;
  assign w_mem_stall = ((r_state == c_RUN) && MemReqM && !MemAckM) ||
                       ((r_state == c_MEM_WAIT) && !MemAckM && !w_timeout);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_RUN;
    else        r_state <= w_state_next;
  end

  // Next-state: enter wait on an unacknowledged access, leave on ack or timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_RUN:      if (MemReqM && !MemAckM)   w_state_next = c_MEM_WAIT;
      c_MEM_WAIT: if (MemAckM || w_timeout)  w_state_next = c_RUN;
      default:                               w_state_next = c_RUN;
    endcase
  end

  // Stall/flush outputs: a memory stall freezes everything and overrides load-use and branch.
  always_comb begin
    StallF = w_lw_stall;
    StallD = w_lw_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = PCSrcE;
    FlushE = w_lw_stall | PCSrcE;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  // Wait counter restarts on entry to MEM_WAIT; error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      if ((r_state == c_RUN) && (w_state_next == c_MEM_WAIT)) r_wait_cnt <= 8'd0;
      else if (r_state == c_MEM_WAIT)                         r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign MemBusy = (r_state == c_MEM_WAIT);
  assign MemErr  = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Saturating event counters for front-end stall cycles and decode flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (StallF && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (FlushD && (r_flush_count  != 32'hFFFF_FFFF)) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushCount  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Scoreboard bench for pipeline_ctrl: directed hazard scenarios
//            followed by random traffic, expected values from a behavioural
//            model, plus asynchronous reset checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int MEM_TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemBusy, MemErr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemBusy(MemBusy), .MemErr(MemErr)
`ifdef PIPE_CTRL_PERF_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       rwm, rww, pcs, req, ack;
  } stim_t;

  typedef struct {
    logic        sf, sd, se, sm, fd, fe, fw;
    logic [1:0]  fa, fb;
    logic        busy, err;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: is an access outstanding, how many wait cycles elapsed, error seen, event totals.
  bit          m_wait;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_sc, m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rdm, input logic rwm,
                                     input logic [4:0] rdw, input logic rww);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic apply(input stim_t s);
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
    RdM = s.rdm; RdW = s.rdw; ResultSrcE = s.rsrc; RegWriteM = s.rwm;
    RegWriteW = s.rww; PCSrcE = s.pcs; MemReqM = s.req; MemAckM = s.ack;
  endtask

  // One clock of stimulus: predict this cycle's outputs, queue them, then advance the model.
  task automatic drive(input stim_t s);
    exp_t e;
    bit   lw, ms, to;
    @(posedge clk); #1;
    apply(s);
    lw = (s.rsrc == 2'b01) && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (!m_wait) begin
      to = 0;
      ms = s.req && !s.ack;
    end else begin
      to = (m_waited == MEM_TO - 1) && !s.ack;
      ms = !s.ack && !to;
    end
    e.sf = ms | lw; e.sd = ms | lw;
    e.se = ms; e.sm = ms; e.fw = ms;
    e.fd = !ms && s.pcs;
    e.fe = !ms && (lw || s.pcs);
    e.fa = fwd(s.rs1e, s.rdm, s.rwm, s.rdw, s.rww);
    e.fb = fwd(s.rs2e, s.rdm, s.rwm, s.rdw, s.rww);
    e.busy = m_wait; e.err = m_err; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    if (e.sf && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (e.fd && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (!m_wait) begin
      if (ms) begin m_wait = 1; m_waited = 0; end
    end else if (s.ack || to) begin
      m_wait = 0;
      if (to) m_err = 1;
    end else begin
      m_waited++;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
    s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
    s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
    s.rdw  = 5'($urandom_range(0, 3)); s.rsrc = 2'($urandom_range(0, 3));
    s.rwm  = 1'($urandom_range(0, 1)); s.rww  = 1'($urandom_range(0, 1));
    s.pcs  = ($urandom_range(0, 3) == 0);
    s.req  = ($urandom_range(0, 2) == 0);
    s.ack  = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued prediction.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("StallF", 32'(StallF), 32'(e.sf));
      check("StallD", 32'(StallD), 32'(e.sd));
      check("StallE", 32'(StallE), 32'(e.se));
      check("StallM", 32'(StallM), 32'(e.sm));
      check("FlushD", 32'(FlushD), 32'(e.fd));
      check("FlushE", 32'(FlushE), 32'(e.fe));
      check("FlushW", 32'(FlushW), 32'(e.fw));
      check("ForwardAE", 32'(ForwardAE), 32'(e.fa));
      check("ForwardBE", 32'(ForwardBE), 32'(e.fb));
      check("MemBusy", 32'(MemBusy), 32'(e.busy));
      check("MemErr", 32'(MemErr), 32'(e.err));
`ifdef PIPE_CTRL_PERF_EN
      check("StallCycles", StallCycles, e.sc);
      check("FlushCount", FlushCount, e.fc);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_StallF"}, 32'(StallF), 0);
    check({tag, "_StallD"}, 32'(StallD), 0);
    check({tag, "_StallE"}, 32'(StallE), 0);
    check({tag, "_StallM"}, 32'(StallM), 0);
    check({tag, "_FlushD"}, 32'(FlushD), 0);
    check({tag, "_FlushE"}, 32'(FlushE), 0);
    check({tag, "_FlushW"}, 32'(FlushW), 0);
    check({tag, "_ForwardAE"}, 32'(ForwardAE), 0);
    check({tag, "_ForwardBE"}, 32'(ForwardBE), 0);
    check({tag, "_MemBusy"}, 32'(MemBusy), 0);
    check({tag, "_MemErr"}, 32'(MemErr), 0);
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_StallCycles"}, StallCycles, 0);
    check({tag, "_FlushCount"}, FlushCount, 0);
`endif
  endtask

  initial begin
    stim_t z, s;
    int    n;
    z = '0;
    rst_n = 1'b0;
    apply(z);
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Forwarding: M beats W, then W alone, then writes to x0 never forward.
    s = z; s.rwm = 1; s.rdm = 5; s.rs1e = 5; s.rww = 1; s.rdw = 5; drive(s);
    s.rdm = 0; drive(s);
    s.rdw = 0; s.rs1e = 0; s.rs2e = 0; drive(s);
    // Load-use for one cycle, then clear.
    s = z; s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7; drive(s);
    drive(z);
    // Branch together with load-use.
    s.pcs = 1; drive(s);
    drive(z);
    // Three-cycle memory wait then ack.
    s = z; s.req = 1;
    repeat (3) drive(s);
    s.ack = 1; drive(s);
    drive(z);
    // Access acked in the same cycle it starts.
    drive(s);
    drive(z);
    // Timeout with ack held low.
    s = z; s.req = 1;
    repeat (MEM_TO + 1) drive(s);
    drive(z);

    // Random traffic.
    repeat (400) drive(rand_stim());

    // Drive into MEM_WAIT with the error flag set, then reset mid-wait.
    s = z; s.req = 1;
    n = 0;
    while (!(m_wait && m_err) && n < 20) begin
      drive(s);
      n++;
    end
    check("reach_wait_with_err", 32'(m_wait && m_err), 1);
    @(posedge clk); #1;
    check("pre_reset_MemBusy", 32'(MemBusy), 1);
    check("pre_reset_MemErr", 32'(MemErr), 1);
    #2;
    rst_n = 1'b0;
    apply(z);
    #1;
    check_all_zero("midwait_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Traffic after reset, including a fresh wait.
    s = z; s.req = 1;
    repeat (2) drive(s);
    s.ack = 1; drive(s);
    repeat (50) drive(rand_stim());
    drive(z);
    @(posedge clk); #1;
    check("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
